// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Optional checksum trailer: IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  // Length field is a little-endian 16-bit word count.
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned LEN_W          = 8 * LEN_BYTES;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_BYTE,
    ST_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHK,
`endif
    ST_DONE,
    ST_ERROR
  } ld_state_e;

  // States in which a stream byte may be consumed.
  function automatic logic is_ready_state(input ld_state_e s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_BYTE)
`ifdef IMEM_LOADER_CHECKSUM_EN
           || (s == ST_CHK)
`endif
           ;
  endfunction

  // States that make up an active load.
  function automatic logic is_busy_state(input ld_state_e s);
    return is_ready_state(s) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/imem_loader_word_asm.sv
// Little-endian word assembler: byte counter plus 32-bit assembly register.
// `full` is high when the next loaded byte completes the word.
module loader_word_asm
  import imem_loader_pkg::*;
(
  input  logic        clk_in,
  input  logic        reset,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [31:0]           word_q, word_d;

  // Place each incoming byte into the lane selected by the byte counter.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clr) begin
      idx_d  = '0;
      word_d = '0;
    end else if (load) begin
      case (idx_q)
        2'd0:    word_d[7:0]   = byte_in;
        2'd1:    word_d[15:8]  = byte_in;
        2'd2:    word_d[23:16] = byte_in;
        default: word_d[31:24] = byte_in;
      endcase
      idx_d = idx_q + 1'b1;
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;
  assign full = (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time IMEM loader: length-prefixed little-endian byte stream into
// instruction RAM from word 0, holding the CPU in reset until loaded.
// Optional trailing XOR checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              imem_wena,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned CAPACITY = 1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam ld_state_e ST_FINISH = ST_CHK;
`else
  localparam ld_state_e ST_FINISH = ST_DONE;
`endif

  ld_state_e         state_q, state_d;
  logic              start_q;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              s_ready_q, s_ready_d;
  logic              wena_q, wena_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              accept;
  logic [LEN_W-1:0]  len_full;
  logic              asm_clr, asm_load, asm_full;
  logic [31:0]       asm_word;

  assign accept   = s_valid && s_ready_q;
  assign len_full = {s_data, len_q[7:0]};

  loader_word_asm u_word_asm (
    .clk_in  (clk_in),
    .reset   (reset),
    .clr     (asm_clr),
    .load    (asm_load),
    .byte_in (s_data),
    .word    (asm_word),
    .full    (asm_full)
  );

  // Next-state, counter and checksum logic.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    asm_clr  = 1'b0;
    asm_load = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
    if (accept && (state_q != ST_CHK)) csum_d = csum_q ^ s_data;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_q) begin
          state_d = ST_LEN0;
          len_d   = '0;
          wcnt_d  = '0;
          addr_d  = '0;
          asm_clr = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_LEN0: begin
        if (accept) begin
          len_d[7:0] = s_data;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (accept) begin
          len_d = len_full;
          if (32'(len_full) > CAPACITY) state_d = ST_ERROR;
          else if (len_full == '0)      state_d = ST_FINISH;
          else                          state_d = ST_BYTE;
        end
      end
      ST_BYTE: begin
        if (accept) begin
          asm_load = 1'b1;
          if (asm_full) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Address stops at the last word so it never wraps past the top.
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_d == len_q) begin
          state_d = ST_FINISH;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_BYTE;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) state_d = (s_data == csum_q) ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so the registered copies track the state.
  always_comb begin
    s_ready_d   = is_ready_state(state_d);
    wena_d      = (state_d == ST_WRITE);
    busy_d      = is_busy_state(state_d);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERROR);
    cpu_reset_d = (state_d != ST_DONE);
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      len_q       <= '0;
      wcnt_q      <= '0;
      addr_q      <= '0;
      s_ready_q   <= 1'b0;
      wena_q      <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      len_q       <= len_d;
      wcnt_q      <= wcnt_d;
      addr_q      <= addr_d;
      s_ready_q   <= s_ready_d;
      wena_q      <= wena_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign s_ready    = s_ready_q;
  assign imem_wena  = wena_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = asm_word;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a stream driver pushes expected IMEM
// writes from a byte-level image model; a monitor pops them on each write.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned CAP    = 1 << ADDR_W;

  logic              clk_in = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              imem_wena;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;

  always #5 clk_in = ~clk_in;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .start      (start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .imem_wena  (imem_wena),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_wr[$];
  wr_t         mon_e;
  logic [7:0]  pay[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every IMEM write must match the head of the scoreboard.
  always @(negedge clk_in) begin
    if (!reset) begin
      if (imem_wena) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                   imem_addr, imem_wdata);
        end else begin
          mon_e = exp_wr.pop_front();
          check32("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
          check32("wr_data", imem_wdata, mon_e.data);
          check1("ready_low_in_write", s_ready, 1'b0);
        end
      end
      check1("cpu_reset_vs_done", cpu_reset, ~done);
    end
  end

  task automatic check_reset_vals();
    check1("rst_s_ready", s_ready, 1'b0);
    check1("rst_wena", imem_wena, 1'b0);
    check32("rst_addr", 32'(imem_addr), 32'd0);
    check32("rst_wdata", imem_wdata, 32'd0);
    check1("rst_cpu_reset", cpu_reset, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_error", error, 1'b0);
  endtask

  task automatic rand_pay(input int unsigned n);
    pay = {};
    for (int unsigned i = 0; i < 4 * n; i++) pay.push_back(8'($urandom));
  endtask

  // Model: N words from payload bytes; N > capacity aborts after the length.
  // mode 0 = continuous valid, 1 = alternate cycles, 2 = random.
  task automatic load_image(input int unsigned n, input logic [7:0] img[$],
                            input int unsigned mode, input bit poke,
                            input int unsigned abort_after, input bit bad_csum);
    logic [7:0]  q[$];
    logic [7:0]  x;
    logic [31:0] word;
    wr_t         e;
    bit          len_err, err, ph, acc;
    int unsigned k, base, guard, w;
    q = {};
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    len_err = (n > CAP);
    err     = len_err;
    base    = len_err ? 3 : 3 + 5 * n;
    if (!len_err) begin
      for (int unsigned i = 0; i < n; i++) begin
        word = 32'(img[4*i]) + (32'(img[4*i+1]) << 8) +
               (32'(img[4*i+2]) << 16) + (32'(img[4*i+3]) << 24);
        for (int unsigned j = 0; j < 4; j++) q.push_back(img[4*i+j]);
        if (abort_after == 0) begin
          e.addr = ADDR_W'(i);
          e.data = word;
          exp_wr.push_back(e);
        end
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!len_err) begin
      x = '0;
      foreach (q[i]) x ^= q[i];
      if (bad_csum) x = ~x;
      q.push_back(x);
      base++;
      err = bad_csum;
    end
`else
    x = 8'(bad_csum);
`endif
    while (q.size() > abort_after && abort_after != 0) void'(q.pop_back());

    @(negedge clk_in);
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk_in);
    start = 1'b0;
    guard = 0;
    ph = 1'b1;
    while (q.size() != 0 && guard < 20000) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       begin s_valid = ph; ph = ~ph; end
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = q[0];
      start  = poke && (guard == 6);
      acc    = s_valid && s_ready;
      @(posedge clk_in);
      if (acc) void'(q.pop_front());
      @(negedge clk_in);
      guard++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    check32("stream_consumed", 32'(q.size()), 32'd0);

    if (abort_after != 0) begin
      reset = 1'b1;
      @(negedge clk_in);
      check_reset_vals();
      reset = 1'b0;
      return;
    end

    w = 0;
    while (!(done || error) && w < 1000) begin
      @(negedge clk_in);
      w++;
    end
    check1("outcome_done", done, !err);
    check1("outcome_error", error, err);
    check1("cpu_reset_final", cpu_reset, err);
    check1("busy_final", busy, 1'b0);
    if (mode == 0) check32("done_cycle", cyc - k, base);
    else check1("stall_not_early", (cyc - k) >= base, 1'b1);
    check32("scoreboard_drained", 32'(exp_wr.size()), 32'd0);
    if (!len_err && n > 0) check32("last_addr", 32'(imem_addr), n - 1);
  endtask

  initial begin
    int unsigned n;
    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(negedge clk_in);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk_in);

    pay = {8'h13, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h80, 8'h20};
    load_image(2, pay, 0, 1'b0, 0, 1'b0);
    load_image(2, pay, 1, 1'b0, 0, 1'b0);
    load_image(129, pay, 0, 1'b0, 0, 1'b0);
    rand_pay(3);
    load_image(3, pay, 2, 1'b0, 0, 1'b0);
    rand_pay(2);
    load_image(2, pay, 0, 1'b0, 4, 1'b0);
    rand_pay(2);
    load_image(2, pay, 2, 1'b0, 0, 1'b0);
    rand_pay(128);
    load_image(128, pay, 0, 1'b0, 0, 1'b0);
    load_image(0, pay, 0, 1'b0, 0, 1'b0);
    rand_pay(4);
    load_image(4, pay, 0, 1'b1, 0, 1'b0);

    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(0, 6);
      if (it % 5 == 4) n = $urandom_range(129, 400);
      rand_pay(n);
      load_image(n, pay, $urandom_range(0, 2),
                 (n >= 2) ? 1'($urandom_range(0, 1)) : 1'b0, 0, 1'b0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    pay = {8'h13, 8'h00, 8'h00, 8'h00};
    load_image(1, pay, 0, 1'b0, 0, 1'b0);
    load_image(1, pay, 0, 1'b0, 0, 1'b1);
`endif

    repeat (2) @(negedge clk_in);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
